// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - burst reader from a registered-read RAM into a valid/ready stream
// A 2-entry buffer plus a credit check on issue hides the RAM's one-cycle read latency.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic [ADDR_WIDTH:0]   beat_cnt;
  logic                  in_flight;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  pop;
  logic                  issue;
  logic [2:0]            pending;

  assign ram_read_addr = rd_ptr;
  assign m_valid       = (occ != 2'd0);
  assign m_data        = head_q;
  assign pop           = m_valid && m_ready;

  // Entries that will still occupy the buffer after this edge; a new read needs a free slot.
  assign pending = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
  assign issue   = (state == RUN) && (issue_cnt != '0) && (pending < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_ptr    <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      in_flight <= 1'b0;
      occ       <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        rd_ptr    <= rd_ptr + 1'b1;
        issue_cnt <= issue_cnt - 1'b1;
      end

      case ({in_flight, pop})
        2'b10: begin
          if (occ == 2'd0) head_q <= ram_q;
          else             tail_q <= ram_q;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_q <= ram_q;
          end else begin
            head_q <= tail_q;
            tail_q <= ram_q;
          end
        end
        default: ;
      endcase

      if (pop) beat_cnt <= beat_cnt - 1'b1;

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rd_ptr    <= base_addr;
            issue_cnt <= length;
            beat_cnt  <= length;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pop && beat_cnt == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - directed bench with a RAM model and an expected-word scoreboard
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] base_addr = '0;
  logic [6:0] length = '0;
  logic       busy;
  logic       done;
  logic [5:0] ram_read_addr;
  logic [7:0] ram_q = '0;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;

  logic [7:0] mem [64];
  logic [7:0] sb [$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_read_addr];

  ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_read_addr(ram_read_addr), .ram_q(ram_q),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: m_ready held high; mode 1: random 3-cycle stalls. inject: stray start mid-burst.
  task automatic run_burst(input int base, input int len, input int mode, input bit inject);
    int k, transfers, dones, first_valid, stall, issued;
    bit exp_done, last_seen, finished, held_valid, nxt_done;
    logic [7:0] held_data, exp;
    logic [5:0] idx;
    k = 1; transfers = 0; dones = 0; first_valid = -1; stall = 0;
    exp_done = (len == 0); last_seen = (len == 0); finished = 0; held_valid = 0; held_data = '0;
    @(negedge clk);
    start = 1'b1; base_addr = 6'(base); length = 7'(len);
    for (int i = 0; i < len; i++) begin
      idx = 6'((base + i) % 64);
      sb.push_back(mem[idx]);
    end
    @(negedge clk);
    start = 1'b0;
    while (k <= 400 && !finished) begin
      chk("done", 32'(done), 32'(exp_done));
      if (done) dones++;
      chk("busy", 32'(busy), 32'(!last_seen));
      if (exp_done) begin
        chk("no_valid_at_done", 32'(m_valid), 32'd0);
        finished = 1;
      end else begin
        if (held_valid) begin
          chk("stall_valid", 32'(m_valid), 32'd1);
          chk("stall_data", 32'(m_data), 32'(held_data));
        end
        if (mode == 0) m_ready = 1'b1;
        else if (stall > 0) begin m_ready = 1'b0; stall--; end
        else if ($urandom_range(0, 2) == 0) begin m_ready = 1'b0; stall = 2; end
        else m_ready = 1'b1;
        if (mode == 0 && k <= len && k <= 4)
          chk("read_addr", 32'(ram_read_addr), 32'((base + k - 1) % 64));
        if (mode == 1) begin
          issued = (int'(ram_read_addr) - base + 64) % 64;
          chk("reads_ahead_le2", 32'(issued - transfers <= 2), 32'd1);
        end
        if (inject && k == 3) begin start = 1'b1; base_addr = 6'd20; length = 7'd5; end
        if (inject && k == 4) start = 1'b0;
        if (m_valid && first_valid < 0) first_valid = k;
        nxt_done = 0;
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            chk("extra_beat", 32'd1, 32'd0);
          end else begin
            exp = sb.pop_front();
            chk("m_data", 32'(m_data), 32'(exp));
            if (sb.size() == 0) begin nxt_done = 1; last_seen = 1; end
          end
          transfers++;
        end
        held_valid = m_valid && !m_ready;
        held_data  = m_data;
        exp_done   = nxt_done;
        @(negedge clk);
        k++;
      end
    end
    chk("burst_finished", 32'(finished), 32'd1);
    chk("transfers", 32'(transfers), 32'(len));
    chk("done_pulses", 32'(dones), 32'd1);
    if (mode == 0 && len > 0) chk("first_valid_cycle", 32'(first_valid), 32'd3);
    m_ready = 1'b0;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 8'h10);

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_addr", 32'(ram_read_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_burst(0, 4, 0, 0);
    run_burst(62, 4, 0, 0);
    run_burst(5, 8, 1, 0);
    run_burst(0, 0, 0, 0);
    run_burst(0, 6, 0, 1);
    run_burst(32, 64, 0, 0);

    // Reset mid-burst after two beats
    @(negedge clk);
    start = 1'b1; base_addr = 6'd0; length = 7'd8; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_data", 32'(m_data), 32'd0);
    chk("arst_addr", 32'(ram_read_addr), 32'd0);
    @(negedge clk);
    chk("arst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    m_ready = 1'b0;
    run_burst(0, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side master for the simple dual-port single-clock RAM: fetches a contiguous block of words and delivers them over a valid/ready stream.
- On `start`, it walks `length` addresses from `base_addr` and drives the RAM read address.
- It absorbs the RAM's 1-cycle registered read latency with a 2-entry output buffer, so it sustains 1 word/cycle and survives arbitrary downstream backpressure.
- Sits between the RAM read port and any downstream consumer (DMA/packetizer); the RAM write port is untouched.

Parameters:
- DATA_WIDTH, 8, width of RAM word and stream data.
- ADDR_WIDTH, 6, RAM address width; depth = 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock, rising edge; same clock as the RAM.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first RAM address; sampled with start.
- length  input  ADDR_WIDTH+1  number of words, 0..2**ADDR_WIDTH; sampled with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at burst completion.
- ram_read_addr  output  ADDR_WIDTH  to RAM read_addr.
- ram_q  input  DATA_WIDTH  from RAM q; registered read data, valid 1 cycle after address.
- m_valid  output  1  stream data valid.
- m_data  output  DATA_WIDTH  stream data.
- m_ready  input  1  downstream accept; a beat transfers when m_valid && m_ready.

Behaviour:
- Reset (async assert, sync deassert at the consumer's discretion):
  - state=IDLE; busy=0, done=0, m_valid=0, m_data=0, ram_read_addr=0.
  - Buffer empty; in-flight flag cleared; all counters 0.
- FSM states:
  - IDLE: on start=1, latch base_addr into rd_ptr, latch length into issue_cnt and beat_cnt. If length==0, go to DONE; else go to RUN.
  - RUN: issue reads and return data. When beat_cnt reaches 0 (last beat accepted), go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- start is ignored outside IDLE; no queuing.
- ram_read_addr is driven combinationally from rd_ptr. The RAM reads every cycle; only "issued" reads are tracked.
- Issue condition (RUN): issue_cnt>0 && (occ + in_flight - pop) < 2.
  - occ = buffer entries (0..2).
  - in_flight = a read issued last cycle.
  - pop = m_valid && m_ready this cycle.
- On issue: rd_ptr <= rd_ptr+1, wrapping mod 2**ADDR_WIDTH; issue_cnt decrements; in_flight <= 1. Otherwise in_flight <= 0.
- When in_flight=1, ram_q is written into the buffer tail at the next edge. The buffer never overflows, guaranteed by the credit rule.
- m_valid = occ>0; m_data = buffer head. Data is stable while m_valid && !m_ready.
- beat_cnt decrements on each pop.
- Latency, with start sampled at edge E0:
  - ram_read_addr=base during cycle E0..E1.
  - m_valid=1 with word[base] after E2.
  - With m_ready held high, beats are back-to-back, one per cycle.
- done rises the cycle after the last beat's transfer edge.
- busy is high in RUN only. In IDLE and DONE it is low; for length 0, busy never rises and done pulses 1 cycle after start.
- Simultaneous push and pop on the same edge: occ unchanged; order is preserved (FIFO).
- Concurrent RAM writes to an address being read: the block returns whatever ram_q delivers (RAM old-data semantics). No hazard check.
- length = 2**ADDR_WIDTH: every address is read exactly once, starting at base_addr and wrapping.
- Reset mid-burst: everything is aborted immediately; buffered and in-flight data are discarded; no done pulse.

Test Plan:
- RAM preloaded ram[i]=i+8'h10; start with base=0, len=4, m_ready=1 -> m_valid 2 cycles after start; m_data 10,11,12,13 on consecutive cycles; done 1 cycle after the 13 transfer; busy low afterwards.
- base=62, len=4, m_ready=1 -> ram_read_addr 62,63,0,1; m_data 4E,4F,10,11.
- base=5, len=8, m_ready toggled pseudo-randomly with 3-cycle stalls -> exactly 15..1C in order, no drops or duplicates; m_data stable during stalls; at most 2 reads ahead of the consumer.
- len=0 -> no m_valid, busy stays 0, done pulses once 1 cycle after start. Start pulse while busy (base=20) -> ignored; the current burst completes unchanged.
- len=64, base=32, m_ready=1 -> 64 beats 30..4F then 10..2F; exactly 64 transfers; single done pulse.
- rst_n low in mid-burst after 2 beats -> outputs return to 0 immediately and asynchronously; no done. A new burst base=0, len=2 after release -> 10,11 correctly.
